// File: rtl/cache_pkg.sv
// Shared widths and transfer states for the direct-mapped data cache.
// Address split is {tag, index, offset}; all widths derive from the four sizes below.
package cache_pkg;

  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;

  localparam int unsigned INDEX_W  = $clog2(NUM_LINES);
  localparam int unsigned OFFSET_W = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned BLOCK_W  = ADDR_W - OFFSET_W;
  localparam int unsigned LINE_W   = BLOCK_BYTES * DATA_W;

  // One cache line as an array of bytes.
  typedef logic [BLOCK_BYTES-1:0][DATA_W-1:0] line_t;

  // Memory-side sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    GAP
  } state_t;

endpackage

// File: rtl/block_transfer_unit.sv
// Moves one cache block as BLOCK_BYTES single-byte memory transactions,
// with a one-cycle request-free GAP after every byte so the memory re-arms.
// Ports:
//   clock, reset        clock, asynchronous active-high reset
//   start, direction    launch a block (direction 1 = write to memory, 0 = read)
//   block_address       {tag, index} of the block, latched at launch
//   line_data           line contents supplying write bytes
//   mem_*               registered memory request, address and write data; busywait in
//   busy                a block is in progress (including its gaps)
//   capture             read byte byte_index completes at this rising edge
//   done                final GAP of a block; start may chain the next block here
module block_transfer_unit
  import cache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                direction,
  input  logic [BLOCK_W-1:0]  block_address,
  input  logic [LINE_W-1:0]   line_data,
  input  logic                mem_busywait,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                busy,
  output logic                capture,
  output logic                done,
  output logic [OFFSET_W-1:0] byte_index
);

  state_t               state;
  logic                 write_q;
  logic [BLOCK_W-1:0]   block_q;
  logic [OFFSET_W-1:0]  count;
  line_t                line_bytes;
  logic                 launch;

  assign line_bytes = line_data;
  assign busy       = (state != IDLE);
  assign done       = (state == GAP) && (count == '0);
  assign capture    = (state == FILL) && !mem_busywait;
  assign byte_index = count;
  // A new block may begin from IDLE or straight out of the previous block's last gap.
  assign launch     = start && ((state == IDLE) || done);

  // Byte sequencer; count wraps to zero after the last byte, marking the phase end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      write_q       <= 1'b0;
      block_q       <= '0;
      count         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (launch) begin
            state         <= direction ? WRITEBACK : FILL;
            write_q       <= direction;
            block_q       <= block_address;
            count         <= '0;
            mem_read      <= !direction;
            mem_write     <= direction;
            mem_address   <= {block_address, OFFSET_W'(0)};
            mem_writedata <= line_bytes[0];
          end else if ((state == GAP) && (count != '0)) begin
            state         <= write_q ? WRITEBACK : FILL;
            mem_read      <= !write_q;
            mem_write     <= write_q;
            mem_address   <= {block_q, count};
            mem_writedata <= line_bytes[count];
          end else begin
            state <= IDLE;
          end
        end
        WRITEBACK, FILL: begin
          if (!mem_busywait) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            count     <= count + OFFSET_W'(1);
            state     <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache between the CPU
// load/store port and a byte-wide data memory. Hits are zero-wait; misses
// write back a dirty victim (if any) then fill the line one byte at a time.
// Ports:
//   clock, reset                    clock, asynchronous active-high reset
//   cpu_read, cpu_write             CPU request levels (both high = no request)
//   cpu_address, cpu_writedata      CPU byte address and store data
//   cpu_readdata, cpu_busywait      load data and stall (combinational)
//   mem_read, mem_write             memory requests (registered)
//   mem_address, mem_writedata      memory address and store data (registered)
//   mem_readdata, mem_busywait      memory load data and stall
module data_cache_controller
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_array  [NUM_LINES];
  line_t                data_array [NUM_LINES];

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  line_t               line;
  logic [BLOCK_W-1:0]  block_address;
  logic [OFFSET_W-1:0] byte_index;
  logic request, hit, busy, capture, done, start, direction;
  logic write_hit, last_capture;

  assign {tag, index, offset} = cpu_address;
  assign line    = data_array[index];
  assign request = cpu_read ^ cpu_write;
  assign hit     = valid[index] && (tag_array[index] == tag);

  // Miss handling: launch from idle, or chain the fill out of the writeback's last gap.
  assign start         = request && !hit && (!busy || done);
  assign direction     = !busy && dirty[index];
  assign block_address = direction ? {tag_array[index], index} : {tag, index};

  assign write_hit    = cpu_write && !cpu_read && hit && !busy;
  assign last_capture = capture && (byte_index == OFFSET_W'(BLOCK_BYTES - 1));

  assign cpu_busywait = !reset && request && (busy || !hit);
  assign cpu_readdata = (cpu_read && !cpu_write && hit && !busy) ? line[offset] : '0;

  // Line status bits; the only cache state cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (last_capture) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (write_hit) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data storage, not reset.
  always_ff @(posedge clock) begin
    if (capture) begin
      data_array[index][byte_index] <= mem_readdata;
      if (last_capture) begin
        tag_array[index] <= tag;
      end
    end else if (write_hit) begin
      data_array[index][offset] <= cpu_writedata;
    end
  end

  block_transfer_unit u_transfer (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .direction     (direction),
    .block_address (block_address),
    .line_data     (line),
    .mem_busywait  (mem_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .busy          (busy),
    .capture       (capture),
    .done          (done),
    .byte_index    (byte_index)
  );

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a byte memory model of
// programmable latency, a transaction log and a request-gap monitor.
module tb_data_cache_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_read, cpu_write;
  logic [7:0] cpu_address, cpu_writedata;
  logic [7:0] cpu_readdata;
  logic       cpu_busywait;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_writedata, mem_readdata;
  logic       mem_busywait;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  data_cache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Memory model: request held for mem_lat cycles per byte, shares the reset.
  logic [7:0]  mem [256] = '{default: 8'h00};
  int unsigned wait_cnt;
  int          mem_lat = 2;

  assign mem_busywait = (mem_read || mem_write) && (wait_cnt + 1 < mem_lat);
  assign mem_readdata = mem[mem_address];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
    end else if (mem_read || mem_write) begin
      if (mem_busywait) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
        if (mem_write) mem[mem_address] = mem_writedata;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Completed memory transactions in order.
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;
  txn_t log_q[$];

  always @(posedge clock) begin
    if (!reset && (mem_read || mem_write) && !mem_busywait)
      log_q.push_back('{mem_write, mem_address, mem_write ? mem_writedata : mem_readdata});
  end

  // Request-level monitor sampled on the falling edge.
  int   req_samples = 0;
  int   gap_errs = 0;
  int   overlap_errs = 0;
  int   low_run = 0;
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clock) begin
    if (mem_read && mem_write) overlap_errs++;
    if (mem_read || mem_write) req_samples++;
    if ((mem_read || mem_write) && !prev_req && prev_busy && low_run != 1) gap_errs++;
    low_run   = (mem_read || mem_write) ? 0 : low_run + 1;
    prev_req  = mem_read || mem_write;
    prev_busy = cpu_busywait;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          lat;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    int          exp_busy;
    int          nrd;
    int          nwr;
    logic [7:0]  wb_base;
    logic [7:0]  fill_base;
    logic [31:0] wb_data;
  } vec_t;

  // Issue one CPU access, hold it until the stall clears, then check everything.
  task automatic apply_vec(input vec_t v, input string name);
    int base, rs0, nb, n, nr, nw;
    @(negedge clock);
    #2;
    mem_lat       = v.lat;
    cpu_read      = v.rd;
    cpu_write     = v.wr;
    cpu_address   = v.addr;
    cpu_writedata = v.wdata;
    base = log_q.size();
    rs0  = req_samples;
    #1;
    nb = 0;
    while (cpu_busywait && nb < 200) begin
      @(negedge clock);
      #1;
      if (cpu_busywait) nb++;
    end
    check({name, " busy cycles"}, 32'(nb), 32'(v.exp_busy));
    if (v.chk_rd) check({name, " readdata"}, 32'(cpu_readdata), 32'(v.exp_rd));
    n = log_q.size() - base;
    nr = 0;
    nw = 0;
    for (int k = 0; k < n; k++) begin
      if (log_q[base+k].wr) nw++;
      else nr++;
    end
    check({name, " mem reads"}, 32'(nr), 32'(v.nrd));
    check({name, " mem writes"}, 32'(nw), 32'(v.nwr));
    check({name, " request cycles"}, 32'(req_samples - rs0), 32'((v.nrd + v.nwr) * v.lat));
    if (n == v.nrd + v.nwr) begin
      for (int k = 0; k < v.nwr; k++) begin
        check($sformatf("%s wb%0d addr", name, k), {23'd0, log_q[base+k].wr, log_q[base+k].addr},
              {23'd0, 1'b1, 8'(v.wb_base + 8'(k))});
        check($sformatf("%s wb%0d data", name, k), 32'(log_q[base+k].data), 32'(v.wb_data[8*k +: 8]));
      end
      for (int k = 0; k < v.nrd; k++) begin
        check($sformatf("%s fill%0d addr", name, k),
              {23'd0, log_q[base+v.nwr+k].wr, log_q[base+v.nwr+k].addr},
              {23'd0, 1'b0, 8'(v.fill_base + 8'(k))});
      end
    end
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  vec_t vecs[14];
  vec_t post_reset;

  initial begin
    int wc;
    int base;

    //            rd    wr    addr   wdata lat chk  exp_rd busy nrd nwr wb_base fill   wb_data
    vecs[0]  = '{1'b0, 1'b1, 8'h05, 8'hAB, 2, 1'b0, 8'h00, 12, 4, 0, 8'h00, 8'h04, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 8'h05, 8'h00, 2, 1'b1, 8'hAB,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 8'h25, 8'h00, 2, 1'b1, 8'h00, 24, 4, 4, 8'h04, 8'h24, 32'h0000AB00};
    vecs[3]  = '{1'b1, 1'b0, 8'h05, 8'h00, 2, 1'b1, 8'hAB, 12, 4, 0, 8'h00, 8'h04, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 8'h06, 8'h3C, 2, 1'b0, 8'h00,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 8'h1F, 8'h77, 1, 1'b0, 8'h00,  8, 4, 0, 8'h00, 8'h1C, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 8'h1F, 8'h00, 1, 1'b1, 8'h77,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1, 1'b1, 8'h3C,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1, 1'b1, 8'h00, 16, 4, 4, 8'h1C, 8'hFC, 32'h77000000};
    vecs[9]  = '{1'b1, 1'b0, 8'h1F, 8'h00, 1, 1'b1, 8'h77,  8, 4, 0, 8'h00, 8'h1C, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 8'h05, 8'hFF, 1, 1'b0, 8'h00,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 8'h45, 8'hFF, 1, 1'b0, 8'h00,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 8'h05, 8'h00, 1, 1'b1, 8'hAB,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 8'h06, 8'h00, 1, 1'b1, 8'h3C,  0, 0, 0, 8'h00, 8'h00, 32'h0};
    post_reset = '{1'b1, 1'b0, 8'h05, 8'h00, 2, 1'b1, 8'hAB, 12, 4, 0, 8'h00, 8'h04, 32'h0};

    reset         = 1'b1;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_address   = 8'h00;
    cpu_writedata = 8'h00;

    // Reset values.
    @(negedge clock);
    @(negedge clock);
    #1;
    check("reset mem_read", 32'(mem_read), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset mem_address", 32'(mem_address), 32'd0);
    check("reset mem_writedata", 32'(mem_writedata), 32'd0);
    check("reset cpu_readdata", 32'(cpu_readdata), 32'd0);
    check("reset cpu_busywait", 32'(cpu_busywait), 32'd0);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

    // Reset while the second fill byte is on the bus aborts the miss at once.
    @(negedge clock);
    #2;
    mem_lat     = 2;
    cpu_address = 8'h14;
    cpu_read    = 1'b1;
    base = log_q.size();
    wc = 0;
    #1;
    while (!((log_q.size() == base + 1) && mem_read) && wc < 50) begin
      @(negedge clock);
      #1;
      wc++;
    end
    check("reach second fill byte", 32'(wc < 50), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("abort mem_read", 32'(mem_read), 32'd0);
    check("abort mem_write", 32'(mem_write), 32'd0);
    check("abort cpu_busywait", 32'(cpu_busywait), 32'd0);
    check("abort mem_address", 32'(mem_address), 32'd0);
    @(negedge clock);
    #2;
    cpu_read = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b0;
    // Line 1 was dirty before reset; now it must miss with no writeback.
    apply_vec(post_reset, "post-reset");

    check("request gaps", 32'(gap_errs), 32'd0);
    check("read/write overlap", 32'(overlap_errs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
